fp_unpack_stage: RTL and testbench
==================================

Name: fp_unpack_stage

Overview:
- Input stage of the floating-point datapath. Accepts two packed IEEE-754 operands plus a tag over a valid/ready handshake.
- Splits each operand into sign, effective exponent and significand with the hidden bit made explicit. Classifies each operand.
- Presents the result one cycle later to the downstream arithmetic pipeline stage.
- Contains a two-entry skid buffer, so in_ready is a register output. This breaks the combinational ready path from downstream pipeline control.

Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, stored mantissa field width (excludes hidden bit)
- TAG_W, 4, width of the opaque sideband tag carried with each operand pair

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream pair valid
- in_ready  output  1  stage can accept a pair; registered
- in_a  input  EXP_W+MAN_W+1  packed operand A {sign, exp, man}
- in_b  input  EXP_W+MAN_W+1  packed operand B
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  unpacked pair valid
- out_ready  input  1  downstream accepts
- out_a_sign, out_b_sign  output  1  operand sign
- out_a_exp, out_b_exp  output  EXP_W  effective biased exponent
- out_a_sig, out_b_sig  output  MAN_W+1  significand with explicit hidden bit
- out_a_cls, out_b_cls  output  3  class code
- out_tag  output  TAG_W  tag, passed through unchanged

Behaviour:
- Clock and reset: clock is clock; reset is reset, asynchronous, active-high.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Data is captured only on in_fire. Outputs must hold stable while out_valid=1 and out_ready=0.
- Class codes: 0 zero; 1 subnormal; 2 normal; 3 infinity; 4 quiet NaN (mantissa MSB=1); 5 signalling NaN (mantissa MSB=0, mantissa≠0). Codes 6 and 7 are never produced.
- Unpack rules, applied to each operand:
  - exp=0, man=0: exp_out 0, sig 0.
  - exp=0, man≠0: exp_out 1, sig {0, man}.
  - 0<exp<all-ones: exp_out exp, sig {1, man}.
  - exp all-ones: exp_out exp, sig {1, man}.
  - Sign always passes through, including for zero and NaN.
- Classification and unpack are combinational on the input side. Only unpacked fields are stored in the buffer registers.
- Buffer state machine, 2-bit encoded. Initial state after reset is EMPTY.
  - EMPTY (no valid entry): in_fire → load main, go to ONE.
  - ONE (main valid):
    - in_fire & out_fire → load main, stay in ONE.
    - in_fire & !out_fire → load skid, go to FULL.
    - !in_fire & out_fire → go to EMPTY.
    - otherwise hold.
  - FULL (main and skid valid):
    - out_fire → main<=skid, go to ONE.
    - otherwise hold.
    - No capture is possible in this state because in_ready=0.
- out_valid = (state≠EMPTY). Output fields are always driven from main.
- in_ready is a flop. It is asserted next cycle iff the next state is not FULL.
- Latency and throughput: 1 cycle in_fire→out_valid. Sustained 1 pair/cycle when out_ready=1. Pairs are delivered strictly in order; none are dropped or duplicated.
- Reset values: out_valid 0; in_ready 1; state EMPTY; all data/tag/class outputs 0.
- Reset asserted mid-operation: buffered pairs are discarded immediately. Outputs take their reset values asynchronously. No partial pair is emitted after reset deasserts.
- If in_valid drops without a fire, nothing is captured. Inputs are ignored when in_ready=0.

Optional Feature:
- Macro: FP_UNPACK_FTZ_EN.
- Defined: subnormal inputs are flushed to zero. Class 0, exp_out 0, sig 0, sign preserved. Class 1 is never produced.
- Undefined: subnormals are unpacked as specified above with class 1.
- Timing and handshake behaviour are identical in both builds.

Test Plan:
- Normal operand: in_a=0x3F800000, in_b=0xC0490FDB, tag=0x5, out_ready=1. Required next cycle:
  - A: sign0, exp 0x7F, sig 0x800000, cls 2.
  - B: sign1, exp 0x80, sig 0xC90FDB, cls 2.
  - out_tag 0x5.
- Specials: in_a=0x7FC00000 → cls 4. in_a=0x7F800001 → cls 5. in_b=0xFF800000 → sign1, exp 0xFF, sig 0x800000, cls 3. in_b=0x80000000 → sign1, exp 0, sig 0, cls 0.
- Subnormal: in_a=0x00000001. Without FTZ: exp 1, sig 0x000001, cls 1. With FP_UNPACK_FTZ_EN: exp 0, sig 0, cls 0.
- Backpressure: out_ready=0, in_valid=1 with tags 1,2,3 offered on consecutive cycles.
  - Tags 1 and 2 are accepted; in_ready=0 the cycle after the second capture; tag 3 is held off.
  - Raise out_ready: outputs tag 1, 2, 3 in order, with in_ready reasserting one cycle after the first out_fire.
- Streaming: 16 back-to-back pairs with out_ready=1 → 16 outputs on consecutive cycles, first at cycle 1, in_ready constantly 1.
- Reset mid-operation: FULL state, assert reset → out_valid 0, in_ready 1 immediately. After deassert, a new pair emerges with correct data and no stale tags.

Source files
------------

// File: rtl/fp_unpack_stage.sv
// fp_unpack_stage: input stage of the floating-point datapath.
// Unpacks two packed IEEE-754 operands into sign, effective exponent,
// explicit-hidden-bit significand and a class code. The result is held
// in a two-entry skid buffer, which lets in_ready come from a flop.
//
// Build option: define FP_UNPACK_FTZ_EN to flush subnormal inputs to zero.
// In that build class 1 is never produced. Timing is the same in both builds.
//
// Buffer states:
//   state | meaning
//   EMPTY | no valid entry; out_valid low
//   ONE   | main entry valid and presented on the outputs
//   FULL  | main and skid valid; in_ready low
module fp_unpack_stage #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MAN_W:0]    in_a,
  input  logic [EXP_W+MAN_W:0]    in_b,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_a_sign,
  output logic                    out_b_sign,
  output logic [EXP_W-1:0]        out_a_exp,
  output logic [EXP_W-1:0]        out_b_exp,
  output logic [MAN_W:0]          out_a_sig,
  output logic [MAN_W:0]          out_b_sig,
  output logic [2:0]              out_a_cls,
  output logic [2:0]              out_b_cls,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int W = EXP_W + MAN_W + 1;

  localparam logic [2:0] CLS_ZERO = 3'd0;
  localparam logic [2:0] CLS_SUB  = 3'd1;
  localparam logic [2:0] CLS_NORM = 3'd2;
  localparam logic [2:0] CLS_INF  = 3'd3;
  localparam logic [2:0] CLS_QNAN = 3'd4;
  localparam logic [2:0] CLS_SNAN = 3'd5;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   sig;
    logic [2:0]       cls;
  } op_t;

  typedef struct packed {
    op_t              a;
    op_t              b;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  // Field split and classification of one packed operand.
  function automatic op_t unpack_op(input logic [W-1:0] op);
    op_t              r;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e      = op[W-2:MAN_W];
    m      = op[MAN_W-1:0];
    r.sign = op[W-1];
    r.exp  = e;
    r.sig  = {1'b1, m};
    r.cls  = CLS_NORM;
    if (e == '0) begin
      if (m == '0) begin
        r.exp = '0;
        r.sig = '0;
        r.cls = CLS_ZERO;
      end else begin
`ifdef FP_UNPACK_FTZ_EN
        r.exp = '0;
        r.sig = '0;
        r.cls = CLS_ZERO;
`else
        // Subnormals share the smallest normal scale, so report exponent 1.
        r.exp = {{(EXP_W-1){1'b0}}, 1'b1};
        r.sig = {1'b0, m};
        r.cls = CLS_SUB;
`endif
      end
    end else if (e == '1) begin
      if (m == '0)
        r.cls = CLS_INF;
      else if (m[MAN_W-1])
        r.cls = CLS_QNAN;
      else
        r.cls = CLS_SNAN;
    end
    return r;
  endfunction

  state_t state_q, state_d;
  entry_t main_q, skid_q;
  entry_t in_entry;
  logic   in_fire, out_fire;
  logic   load_main_in, load_main_skid, load_skid;

  // Unpack happens before the buffer; only unpacked fields are stored.
  always_comb begin
    in_entry.a   = unpack_op(in_a);
    in_entry.b   = unpack_op(in_b);
    in_entry.tag = in_tag;
  end

  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next-state and buffer load selection.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain path can move.
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State register and registered in_ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != FULL);
    end
  end

  // Main entry drives the outputs; it refills from input or skid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      main_q <= '0;
    else if (load_main_in)
      main_q <= in_entry;
    else if (load_main_skid)
      main_q <= skid_q;
  end

  // Skid entry catches the pair accepted while the output is stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      skid_q <= '0;
    else if (load_skid)
      skid_q <= in_entry;
  end

  assign out_a_sign = main_q.a.sign;
  assign out_a_exp  = main_q.a.exp;
  assign out_a_sig  = main_q.a.sig;
  assign out_a_cls  = main_q.a.cls;
  assign out_b_sign = main_q.b.sign;
  assign out_b_exp  = main_q.b.exp;
  assign out_b_sig  = main_q.b.sig;
  assign out_b_cls  = main_q.b.cls;
  assign out_tag    = main_q.tag;

endmodule

// File: tb/tb_fp_unpack_stage.sv
// Bench for fp_unpack_stage: directed test-plan steps followed by random
// traffic, checked against a queue-based reference model. Honours
// FP_UNPACK_FTZ_EN in the same way as the design.
module tb_fp_unpack_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_a_sign, out_b_sign;
  logic [7:0]  out_a_exp, out_b_exp;
  logic [23:0] out_a_sig, out_b_sig;
  logic [2:0]  out_a_cls, out_b_cls;
  logic [3:0]  out_tag;

  int compared = 0;
  int mismatched = 0;

  fp_unpack_stage dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a_sign(out_a_sign), .out_b_sign(out_b_sign),
    .out_a_exp(out_a_exp), .out_b_exp(out_b_exp),
    .out_a_sig(out_a_sig), .out_b_sig(out_b_sig),
    .out_a_cls(out_a_cls), .out_b_cls(out_b_cls),
    .out_tag(out_tag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] sig;
    logic [2:0]  cls;
  } op_m;

  typedef struct {
    op_m        a;
    op_m        b;
    logic [3:0] tag;
  } pair_m;

  pair_m q[$];

  // Reference unpack from the IEEE-754 field rules using integer arithmetic.
  function automatic op_m ref_op(input logic [31:0] x);
    op_m r;
    int unsigned e, m;
    e = (x >> 23) & 32'hFF;
    m = x & 32'h7FFFFF;
    r.sign = (x >> 31) & 1;
    if (e == 0 && m == 0) begin
      r.exp = 0; r.sig = 0; r.cls = 0;
    end else if (e == 0) begin
`ifdef FP_UNPACK_FTZ_EN
      r.exp = 0; r.sig = 0; r.cls = 0;
`else
      r.exp = 1; r.sig = 24'(m); r.cls = 1;
`endif
    end else begin
      r.exp = 8'(e);
      r.sig = 24'(m + 32'h800000);
      if (e < 255)               r.cls = 2;
      else if (m == 0)           r.cls = 3;
      else if (m >= 32'h400000)  r.cls = 4;
      else                       r.cls = 5;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Called at a negedge: check outputs against the model, drive one cycle of
  // inputs, advance the model across the rising edge, return at the next negedge.
  task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] t, input logic ordy);
    logic in_f, out_f;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready",  32'(in_ready),  32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("a_sign", 32'(out_a_sign), 32'(q[0].a.sign));
      chk("a_exp",  32'(out_a_exp),  32'(q[0].a.exp));
      chk("a_sig",  32'(out_a_sig),  32'(q[0].a.sig));
      chk("a_cls",  32'(out_a_cls),  32'(q[0].a.cls));
      chk("b_sign", 32'(out_b_sign), 32'(q[0].b.sign));
      chk("b_exp",  32'(out_b_exp),  32'(q[0].b.exp));
      chk("b_sig",  32'(out_b_sig),  32'(q[0].b.sig));
      chk("b_cls",  32'(out_b_cls),  32'(q[0].b.cls));
      chk("tag",    32'(out_tag),    32'(q[0].tag));
    end
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    in_tag    = t;
    out_ready = ordy;
    in_f  = iv && (q.size() < 2);
    out_f = ordy && (q.size() > 0);
    @(posedge clock);
    if (out_f) void'(q.pop_front());
    if (in_f) begin
      pair_m p;
      p.a = ref_op(a);
      p.b = ref_op(b);
      p.tag = t;
      q.push_back(p);
    end
    @(negedge clock);
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] s;
    s = $urandom_range(0, 1) << 31;
    case ($urandom_range(0, 6))
      0: return s;
      1: return s | ($urandom & 32'h7FFFFF) | 32'h1;
      2: return s | (32'($urandom_range(1, 254)) << 23) | ($urandom & 32'h7FFFFF);
      3: return s | 32'h7F800000;
      4: return s | 32'h7FC00000 | ($urandom & 32'h3FFFFF);
      5: return s | 32'h7F800000 | ($urandom & 32'h3FFFFF) | 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready",  32'(in_ready),  1);
    chk("rst_tag",       32'(out_tag),   0);
    chk("rst_a_sig",     32'(out_a_sig), 0);
    reset = 1'b0;
    @(negedge clock);

    // Normal operands
    step(1, 32'h3F800000, 32'hC0490FDB, 4'h5, 1);
    chk("norm_a_exp", 32'(out_a_exp), 32'h7F);
    chk("norm_a_sig", 32'(out_a_sig), 32'h800000);
    chk("norm_a_cls", 32'(out_a_cls), 2);
    chk("norm_b_sign", 32'(out_b_sign), 1);
    chk("norm_b_exp", 32'(out_b_exp), 32'h80);
    chk("norm_b_sig", 32'(out_b_sig), 32'hC90FDB);
    chk("norm_tag", 32'(out_tag), 5);

    // Specials
    step(1, 32'h7FC00000, 32'hFF800000, 4'h6, 1);
    chk("qnan_cls", 32'(out_a_cls), 4);
    chk("inf_b_exp", 32'(out_b_exp), 32'hFF);
    chk("inf_b_sig", 32'(out_b_sig), 32'h800000);
    chk("inf_b_cls", 32'(out_b_cls), 3);
    step(1, 32'h7F800001, 32'h80000000, 4'h7, 1);
    chk("snan_cls", 32'(out_a_cls), 5);
    chk("negzero_sign", 32'(out_b_sign), 1);
    chk("negzero_sig", 32'(out_b_sig), 0);
    chk("negzero_cls", 32'(out_b_cls), 0);

    // Subnormal
    step(1, 32'h00000001, 32'h00000000, 4'h8, 1);
`ifdef FP_UNPACK_FTZ_EN
    chk("sub_exp", 32'(out_a_exp), 0);
    chk("sub_sig", 32'(out_a_sig), 0);
    chk("sub_cls", 32'(out_a_cls), 0);
`else
    chk("sub_exp", 32'(out_a_exp), 1);
    chk("sub_sig", 32'(out_a_sig), 1);
    chk("sub_cls", 32'(out_a_cls), 1);
`endif
    step(0, 0, 0, 0, 1);

    // Backpressure: tags 1,2 accepted, 3 held off until drain begins
    step(1, 32'h3F800000, 32'h40000000, 4'h1, 0);
    step(1, 32'h40400000, 32'h40800000, 4'h2, 0);
    chk("bp_in_ready_low", 32'(in_ready), 0);
    chk("bp_hold_tag", 32'(out_tag), 1);
    step(1, 32'h40A00000, 32'h40C00000, 4'h3, 0);
    chk("bp_still_tag1", 32'(out_tag), 1);
    step(1, 32'h40A00000, 32'h40C00000, 4'h3, 1);
    chk("bp_tag2", 32'(out_tag), 2);
    chk("bp_in_ready_back", 32'(in_ready), 1);
    step(1, 32'h40A00000, 32'h40C00000, 4'h3, 1);
    chk("bp_tag3", 32'(out_tag), 3);
    step(0, 0, 0, 0, 1);

    // Streaming: 16 back-to-back pairs
    for (int i = 0; i < 16; i++) begin
      step(1, rand_op(), rand_op(), 4'(i), 1);
      chk("stream_in_ready", 32'(in_ready), 1);
      chk("stream_tag", 32'(out_tag), 32'(i));
    end
    step(0, 0, 0, 0, 1);

    // Reset while FULL
    step(1, 32'h3F800000, 32'h3F800000, 4'hA, 0);
    step(1, 32'h3F800000, 32'h3F800000, 4'hB, 0);
    chk("full_in_ready", 32'(in_ready), 0);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_tag", 32'(out_tag), 0);
    q.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    step(1, 32'hC0490FDB, 32'h3F800000, 4'h9, 1);
    chk("post_rst_tag", 32'(out_tag), 9);
    chk("post_rst_b_exp", 32'(out_b_exp), 32'h7F);
    step(0, 0, 0, 0, 1);
    chk("post_rst_empty", 32'(out_valid), 0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), rand_op(), rand_op(), 4'($urandom),
           1'($urandom_range(0, 2) != 0));
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
